led_stream_capture: RTL
=======================

# led_stream_capture

Event-driven capture buffer that sits directly downstream of the `led_stream` core, consuming its `led`, `led_on_number` and `cnt` signals. Each change of `led` is recorded as a timestamped sample in a circular buffer. On a programmable `led_on_number` match, the block:

- pulses a trigger,
- records a fixed number of post-trigger samples,
- then drains pre- and post-trigger history oldest-first over a valid/ready port.

It provides the on-chip trigger/sampler function for the LED stream debug build without relying on the vendor debug core.

## Interface

Parameters:
- `DEPTH`, 16: buffer entries; power of two, ≥ 4.
- `POST_DEPTH`, 4: samples stored after the trigger sample; 1 ≤ `POST_DEPTH` < `DEPTH`.

Ports:
- `clk`, in, 1: single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `led_i`, in, 8: LED vector from the `led_stream` core.
- `led_on_number_i`, in, 3: index of the lit LED.
- `cnt_i`, in, 32: free-running tick counter, used as the timestamp.
- `arm_i`, in, 1: one-cycle arm/restart request.
- `trig_number_i`, in, 3: `led_on_number` value that fires the trigger; must be stable while armed.
- `sampler_ready_o`, out, 1: high while in ARMED.
- `trig_ext_o`, out, 1: one-cycle trigger pulse.
- `rd_valid_o`, out, 1: readout sample valid.
- `rd_ready_i`, in, 1: readout accept.
- `rd_data_o`, out, 43: sample, packed as `{led[7:0], led_on_number[2:0], cnt[31:0]}`.
- `done_o`, out, 1: one-cycle pulse when the last sample is accepted.

## Operation

- `led_prev` is registered every cycle from `led_i`; reset value 0.
- Sample event: `led_i != led_prev`. Events are honoured only in ARMED and POST. The sample written is `{led_i, led_on_number_i, cnt_i}` of the event cycle.
- Write behaviour on each event:
  - write at `wr_ptr`;
  - `wr_ptr` increments modulo `DEPTH`;
  - `fill` saturates at `DEPTH`.
- State machine:
  - **IDLE**: waits for `arm_i`.
  - **ARMED**: writes events. An event with `led_on_number_i == trig_number_i` is written as the trigger sample, sets `post_cnt = POST_DEPTH`, and moves to POST.
  - **POST**: each event is written and decrements `post_cnt`. The write that takes `post_cnt` to 0 moves to READOUT.
  - **READOUT**: `rd_ptr` starts at `wr_ptr - fill` (mod `DEPTH`) and `rd_left = fill`. `rd_valid_o` stays high while `rd_left > 0`. On each `rd_valid_o && rd_ready_i`: `rd_ptr++`, `rd_left--`. On the last accept, `done_o` pulses and the state returns to IDLE.
- `arm_i` handling:
  - In IDLE or ARMED: clears `wr_ptr` and `fill`, then enters ARMED. An arm in ARMED is a restart.
  - In POST or READOUT: ignored.
- An `arm_i` coinciding with a sample event takes priority; that event is dropped.
- A trigger can fire on the first event after arming; readout then holds `POST_DEPTH + 1` samples.
- Events during READOUT are not recorded, and the buffer is not overwritten.

## Timing

- Reset values: all outputs 0, state IDLE, all pointers and counters 0. `rd_data_o` content is don't-care while `rd_valid_o` is 0.
- `trig_ext_o` is registered and asserts the cycle after the trigger-sample write edge.
- `sampler_ready_o` is a registered state decode: high the cycle after the accepted `arm_i`, low the cycle after the trigger.
- `rd_valid_o` first asserts the cycle after the final POST write.
- `rd_data_o` is a combinational read at `rd_ptr` from register storage. Under backpressure (`rd_ready_i` low), `rd_valid_o` and `rd_data_o` hold stable.
- Throughput: one sample per cycle when `rd_ready_i` is held high.
- `done_o` is registered and asserts the cycle after the last handshake, coincident with `rd_valid_o` falling.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). Buffer contents need not be cleared.

## Structure

- Package `led_stream_pkg` holds:
  - the sample struct typedef (`led`, `led_on_number`, `cnt`);
  - the state enum (IDLE, ARMED, POST, READOUT);
  - the sample width constant, 43.
- Sub-module `led_stream_capture_ram`: `DEPTH` x 43 register file with one synchronous write port and one asynchronous read port. No reset on storage.
- Pointer/fill arithmetic is done in `$clog2(DEPTH)+1` bits; pointers wrap implicitly at `DEPTH`.

## Test plan

All scenarios use `DEPTH` = 16 and `POST_DEPTH` = 4.

1. **Reset behaviour.** Assert `rst_n` low, toggle `led_i`, release. Expected: all outputs 0, and no `trig_ext_o` or `rd_valid_o` without `arm_i`.
2. **Basic trigger and readout.** Arm, set `trig_number_i` = 5, then drive 12 `led_i` changes with `led_on_number` 0,1,…,7,0,… and `cnt` = 100·k. Expected: `trig_ext_o` pulses once after event 5; 10 samples are read out (events 0–9) in order with `cnt` 0…900; `done_o` pulses once.
3. **Wrap-around.** Drive 30 non-matching events, then a matching event (#30), then 4 more. Expected: 16 samples read out, events 19…34, oldest first.
4. **Backpressure.** Hold `rd_ready_i` low for 5 cycles mid-readout. Expected: `rd_valid_o` stays 1, `rd_data_o` is unchanged, and no sample is lost or duplicated.
5. **Arm handling.**
   - Arm again in ARMED after 3 events. Expected: `fill` restarts and readout excludes those 3 events.
   - Arm in POST. Expected: ignored; readout completes normally.
   - Arm in the same cycle as an event. Expected: the event is dropped.
6. **Reset mid-readout.** Pulse `rst_n` low while `rd_valid_o` = 1. Expected: `rd_valid_o` drops immediately; re-arming and re-triggering then yields a correct fresh capture.

Source files
------------

// File: rtl/led_stream_pkg.sv
// led_stream_pkg: shared sample format and capture FSM states for the LED stream debug sampler
package led_stream_pkg;
    localparam int SAMPLE_W = 43;

    typedef struct packed {
        logic [7:0]  led;
        logic [2:0]  led_on_number;
        logic [31:0] cnt;
    } sample_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        POST    = 2'd2,
        READOUT = 2'd3
    } state_t;
endpackage

// File: rtl/led_stream_capture_ram.sv
// led_stream_capture_ram: DEPTH x SAMPLE_W register file, sync write, async read, no storage reset
module led_stream_capture_ram
    import led_stream_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wa,
    input  logic [SAMPLE_W-1:0]      wd,
    input  logic [$clog2(DEPTH)-1:0] ra,
    output logic [SAMPLE_W-1:0]      rd
);
    logic [SAMPLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;

    assign rd = mem[ra];
endmodule

// File: rtl/led_stream_capture.sv
// led_stream_capture: records led changes with timestamps, triggers on led_on_number, drains history oldest-first
module led_stream_capture
    import led_stream_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int POST_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          led_i,
    input  logic [2:0]          led_on_number_i,
    input  logic [31:0]         cnt_i,
    input  logic                arm_i,
    input  logic [2:0]          trig_number_i,
    output logic                sampler_ready_o,
    output logic                trig_ext_o,
    output logic                rd_valid_o,
    input  logic                rd_ready_i,
    output logic [SAMPLE_W-1:0] rd_data_o,
    output logic                done_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    state_t        state;
    logic [7:0]    led_prev;
    logic [PW-1:0] wr_ptr, fill, rd_ptr, rd_left, post_cnt;
    logic [PW-1:0] wr_nxt, fill_nxt;
    logic          ev, arm_ok, we, hit;
    sample_t       wd;

    assign ev       = led_i != led_prev;
    assign arm_ok   = arm_i && (state == IDLE || state == ARMED);
    assign we       = ev && !arm_ok && (state == ARMED || state == POST);
    assign hit      = state == ARMED && led_on_number_i == trig_number_i;
    assign wr_nxt   = wr_ptr + 1'b1;
    assign fill_nxt = fill == PW'(DEPTH) ? fill : fill + 1'b1;
    assign wd       = '{led: led_i, led_on_number: led_on_number_i, cnt: cnt_i};

    assign sampler_ready_o = state == ARMED;
    assign rd_valid_o      = state == READOUT && rd_left != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            led_prev   <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            rd_ptr     <= '0;
            rd_left    <= '0;
            post_cnt   <= '0;
            trig_ext_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            led_prev   <= led_i;
            trig_ext_o <= 1'b0;
            done_o     <= 1'b0;
            if (arm_ok) begin
                state  <= ARMED;
                wr_ptr <= '0;
                fill   <= '0;
            end else if (we) begin
                wr_ptr <= wr_nxt;
                fill   <= fill_nxt;
                if (hit) begin
                    state      <= POST;
                    post_cnt   <= PW'(POST_DEPTH);
                    trig_ext_o <= 1'b1;
                end else if (state == POST) begin
                    post_cnt <= post_cnt - 1'b1;
                    // oldest retained sample sits fill entries behind the new write pointer
                    if (post_cnt == PW'(1)) begin
                        state   <= READOUT;
                        rd_ptr  <= wr_nxt - fill_nxt;
                        rd_left <= fill_nxt;
                    end
                end
            end else if (rd_valid_o && rd_ready_i) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_left <= rd_left - 1'b1;
                if (rd_left == PW'(1)) begin
                    state  <= IDLE;
                    done_o <= 1'b1;
                end
            end
        end
    end

    led_stream_capture_ram #(.DEPTH(DEPTH)) u_ram (
        .clk (clk),
        .we  (we),
        .wa  (wr_ptr[AW-1:0]),
        .wd  (wd),
        .ra  (rd_ptr[AW-1:0]),
        .rd  (rd_data_o)
    );
endmodule
